// File: rtl/count_seq_monitor_pkg.sv
// Shared types and constants for the count sequence monitor.
// Optional feature macro used by the top: COUNT_SEQ_MONITOR_HIST_EN.
package count_seq_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HUNT   = 2'd1,
      ST_LOCKED = 2'd2
   } csm_state_e;

   localparam int unsigned ERR_CNT_W  = 8;
   localparam int unsigned STEP_CNT_W = 4;
   localparam int unsigned HIST_W     = 16;

endpackage

// File: rtl/csm_next_val.sv
// Combinational expected-next-legal-value generator for the sequence monitor.
// Also flags when ref_val is the last legal value in the counting direction.
module csm_next_val #(
   parameter int unsigned             WIDTH     = 3,
   parameter logic [2**WIDTH-1:0]     SKIP_MASK = '0,
   parameter bit                      DIR_UP    = 1'b1
) (
   input  logic [WIDTH-1:0] ref_val,
   output logic [WIDTH-1:0] nxt_val,
   output logic             is_last
);

   localparam int unsigned NVAL = 2**WIDTH;

   logic [WIDTH-1:0] cand;
   logic             found;

   // Walk outward from ref_val in the counting direction; first unskipped value wins.
   // If nothing else is legal the search lands back on ref_val itself.
   always_comb begin
      nxt_val = ref_val;
      found   = 1'b0;
      cand    = ref_val;
      for (int unsigned k = 1; k <= NVAL; k++) begin
         if (DIR_UP) begin
            cand = ref_val + k[WIDTH-1:0];
         end else begin
            cand = ref_val - k[WIDTH-1:0];
         end
         if (!found && !SKIP_MASK[cand]) begin
            nxt_val = cand;
            found   = 1'b1;
         end
      end
   end

   // A step is a wrap when the next legal value lies behind ref_val numerically.
   always_comb begin
      if (DIR_UP) begin
         is_last = (nxt_val <= ref_val);
      end else begin
         is_last = (nxt_val >= ref_val);
      end
   end

endmodule

// File: rtl/count_seq_monitor.sv
// Monitors an upstream skip/mod-N counter and reports lock, sequence errors and wraps.
// Define COUNT_SEQ_MONITOR_HIST_EN to add per-value occurrence counters (hist_addr/hist_data).
module count_seq_monitor
   import count_seq_monitor_pkg::*;
#(
   parameter int unsigned             WIDTH     = 3,
   parameter logic [2**WIDTH-1:0]     SKIP_MASK = '0,
   parameter bit                      DIR_UP    = 1'b1,
   parameter int unsigned             LOCK_N    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     q_in,
   input  logic                 q_vld,
   input  logic                 clr_err,
`ifdef COUNT_SEQ_MONITOR_HIST_EN
   input  logic [WIDTH-1:0]     hist_addr,
   output logic [HIST_W-1:0]    hist_data,
`endif
   output logic                 locked,
   output logic                 err,
   output logic                 wrap,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int unsigned            NVAL     = 2**WIDTH;
   localparam logic [STEP_CNT_W-1:0] LOCK_TGT = STEP_CNT_W'(LOCK_N);

   csm_state_e               state_q, state_d;
   logic [WIDTH-1:0]         ref_val, ref_d;
   logic [STEP_CNT_W-1:0]    step, step_d, step_inc;
   logic                     err_d, wrap_d;
   logic [ERR_CNT_W-1:0]     err_cnt_d;
   logic [WIDTH-1:0]         exp_val;
   logic                     ref_is_last;
   logic                     legal;

   csm_next_val #(
      .WIDTH     (WIDTH),
      .SKIP_MASK (SKIP_MASK),
      .DIR_UP    (DIR_UP)
   ) u_next_val (
      .ref_val (ref_val),
      .nxt_val (exp_val),
      .is_last (ref_is_last)
   );

   assign legal    = !SKIP_MASK[q_in];
   assign step_inc = step + STEP_CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ref_val <= '0;
         step    <= '0;
         locked  <= 1'b0;
         err     <= 1'b0;
         wrap    <= 1'b0;
         err_cnt <= '0;
      end else begin
         state_q <= state_d;
         ref_val <= ref_d;
         step    <= step_d;
         locked  <= (state_d == ST_LOCKED);
         err     <= err_d;
         wrap    <= wrap_d;
         err_cnt <= err_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ref_d     = ref_val;
      step_d    = step;
      err_d     = 1'b0;
      wrap_d    = 1'b0;
      err_cnt_d = err_cnt;

      if (q_vld) begin
         if (!legal) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
            step_d  = '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_d = ST_HUNT;
                  ref_d   = q_in;
                  step_d  = '0;
               end
               ST_HUNT, ST_LOCKED: begin
                  if (q_in == exp_val) begin
                     ref_d = q_in;
                     if (state_q == ST_HUNT) begin
                        step_d = step_inc;
                        if (step_inc == LOCK_TGT) begin
                           state_d = ST_LOCKED;
                        end
                     end else begin
                        wrap_d = ref_is_last;
                     end
                  end else begin
                     err_d   = 1'b1;
                     state_d = ST_HUNT;
                     ref_d   = q_in;
                     step_d  = '0;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
                  step_d  = '0;
               end
            endcase
         end
      end

      // Clear wins over a same-cycle increment; the err pulse itself is unaffected.
      if (clr_err) begin
         err_cnt_d = '0;
      end else if (err_d && (err_cnt != '1)) begin
         err_cnt_d = err_cnt + ERR_CNT_W'(1);
      end
   end

`ifdef COUNT_SEQ_MONITOR_HIST_EN
   logic [HIST_W-1:0] hist_mem [NVAL];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NVAL; i++) begin
            hist_mem[i] <= '0;
         end
      end else if (clr_err) begin
         for (int unsigned i = 0; i < NVAL; i++) begin
            hist_mem[i] <= '0;
         end
      end else if (q_vld && legal && (hist_mem[q_in] != '1)) begin
         hist_mem[q_in] <= hist_mem[q_in] + HIST_W'(1);
      end
   end

   assign hist_data = hist_mem[hist_addr];
`endif

endmodule

// File: tb/tb_count_seq_monitor.sv
// Self-checking bench: up- and down-counting monitors driven together, checked
// against a queue-based reference model of the legal sequence.
module tb_count_seq_monitor;

   localparam int unsigned W    = 3;
   localparam logic [7:0]  MASK = 8'b1010_0000;
   localparam int unsigned LN   = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] q_in = '0;
   logic       q_vld = 1'b0;
   logic       clr_err = 1'b0;

   logic       locked_up, err_up, wrap_up;
   logic [7:0] err_cnt_up;
   logic       locked_dn, err_dn, wrap_dn;
   logic [7:0] err_cnt_dn;

   always #5 clk = ~clk;

   count_seq_monitor #(
      .WIDTH     (W),
      .SKIP_MASK (MASK),
      .DIR_UP    (1'b1),
      .LOCK_N    (LN)
   ) u_up (
      .clk     (clk),
      .rst     (rst),
      .q_in    (q_in),
      .q_vld   (q_vld),
      .clr_err (clr_err),
      .locked  (locked_up),
      .err     (err_up),
      .wrap    (wrap_up),
      .err_cnt (err_cnt_up)
   );

   count_seq_monitor #(
      .WIDTH     (W),
      .SKIP_MASK (MASK),
      .DIR_UP    (1'b0),
      .LOCK_N    (LN)
   ) u_dn (
      .clk     (clk),
      .rst     (rst),
      .q_in    (q_in),
      .q_vld   (q_vld),
      .clr_err (clr_err),
      .locked  (locked_dn),
      .err     (err_dn),
      .wrap    (wrap_dn),
      .err_cnt (err_cnt_dn)
   );

   int n_checks = 0;
   int n_bad    = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model, index 1 = counting up, 0 = counting down.
   // A run counts consecutive correct steps since the last (re)acquisition.
   int legal_q[$];
   bit m_have [2];
   int m_ref  [2];
   int m_run  [2];
   int m_cnt  [2];
   bit m_err  [2];
   bit m_wrap [2];

   function automatic bit is_legal(input int v);
      return ((MASK >> v) & 8'd1) == 8'd0;
   endfunction

   function automatic int idx_of(input int v);
      foreach (legal_q[i]) if (legal_q[i] == v) return i;
      return -1;
   endfunction

   function automatic int exp_next(input int d, input int r);
      int n = legal_q.size();
      int i = idx_of(r);
      return (d == 1) ? legal_q[(i + 1) % n] : legal_q[(i + n - 1) % n];
   endfunction

   function automatic bit at_end(input int d, input int r);
      return (d == 1) ? (r == legal_q[legal_q.size() - 1]) : (r == legal_q[0]);
   endfunction

   function automatic bit m_locked(input int d);
      return m_have[d] && (m_run[d] >= LN);
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_have[d] = 0; m_ref[d] = 0; m_run[d] = 0;
         m_cnt[d] = 0; m_err[d] = 0; m_wrap[d] = 0;
      end
   endtask

   task automatic model_step(input int v, input bit q, input bit clr);
      for (int d = 0; d < 2; d++) begin
         m_err[d]  = 0;
         m_wrap[d] = 0;
         if (q) begin
            if (!is_legal(v)) begin
               m_err[d] = 1; m_have[d] = 0; m_run[d] = 0;
            end else if (!m_have[d]) begin
               m_have[d] = 1; m_ref[d] = v; m_run[d] = 0;
            end else if (v == exp_next(d, m_ref[d])) begin
               m_wrap[d] = m_locked(d) && at_end(d, m_ref[d]);
               if (m_run[d] < LN) m_run[d]++;
               m_ref[d] = v;
            end else begin
               m_err[d] = 1; m_ref[d] = v; m_run[d] = 0;
            end
         end
         if (clr) m_cnt[d] = 0;
         else if (m_err[d] && m_cnt[d] < 255) m_cnt[d]++;
      end
   endtask

   task automatic compare_all();
      check_eq("up_locked",  locked_up,  m_locked(1));
      check_eq("up_err",     err_up,     m_err[1]);
      check_eq("up_wrap",    wrap_up,    m_wrap[1]);
      check_eq("up_err_cnt", err_cnt_up, m_cnt[1]);
      check_eq("dn_locked",  locked_dn,  m_locked(0));
      check_eq("dn_err",     err_dn,     m_err[0]);
      check_eq("dn_wrap",    wrap_dn,    m_wrap[0]);
      check_eq("dn_err_cnt", err_cnt_dn, m_cnt[0]);
   endtask

   task automatic drive(input int v, input bit q, input bit clr);
      q_in    = 3'(v);
      q_vld   = q;
      clr_err = clr;
      @(posedge clk);
      model_step(v, q, clr);
      #1;
      compare_all();
   endtask

   task automatic async_reset_pulse();
      rst = 1'b1;
      #1;
      model_reset();
      check_eq("rst_up_locked",  locked_up,  0);
      check_eq("rst_up_err_cnt", err_cnt_up, 0);
      check_eq("rst_dn_locked",  locked_dn,  0);
      check_eq("rst_dn_err_cnt", err_cnt_dn, 0);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      for (int v = 0; v < 8; v++) if (is_legal(v)) legal_q.push_back(v);
      model_reset();

      #12;
      rst = 1'b0;
      check_eq("reset_locked",  locked_up,  0);
      check_eq("reset_err",     err_up,     0);
      check_eq("reset_wrap",    wrap_up,    0);
      check_eq("reset_err_cnt", err_cnt_up, 0);

      // Acquire lock counting up.
      drive(0, 1, 0);
      drive(1, 1, 0);
      check_eq("up_not_yet_locked", locked_up, 0);
      drive(2, 1, 0);
      check_eq("up_lock_after_2", locked_up, 1);
      check_eq("up_lock_err_cnt", err_cnt_up, 0);

      // Wrap through the skipped value 5 back to 0.
      drive(3, 1, 0);
      drive(4, 1, 0);
      drive(6, 1, 0);
      check_eq("no_wrap_before_0", wrap_up, 0);
      drive(0, 1, 0);
      check_eq("wrap_pulse", wrap_up, 1);
      check_eq("wrap_locked", locked_up, 1);
      check_eq("wrap_no_err", err_up, 0);
      drive(0, 0, 0);
      check_eq("wrap_one_cycle", wrap_up, 0);
      check_eq("hold_locked", locked_up, 1);

      // Illegal value drops to IDLE; re-acquire from 6.
      drive(1, 1, 0);
      drive(5, 1, 0);
      check_eq("illegal_err", err_up, 1);
      check_eq("illegal_err_cnt", err_cnt_up, 1);
      check_eq("illegal_unlock", locked_up, 0);
      drive(6, 1, 0);
      check_eq("idle_no_err", err_up, 0);
      drive(0, 1, 0);
      drive(1, 1, 0);
      check_eq("relock_after_1", locked_up, 1);

      // Asynchronous reset while locked, between clock edges.
      async_reset_pulse();
      drive(0, 0, 0);

      // Saturation then clear with a simultaneous error.
      for (int i = 0; i < 300; i++) drive(7, 1, 0);
      check_eq("sat_err_cnt", err_cnt_up, 255);
      drive(7, 1, 1);
      check_eq("clr_err_cnt", err_cnt_up, 0);
      check_eq("clr_err_pulse", err_up, 1);

      // Down-counting lock, then a legal out-of-sequence value.
      drive(6, 1, 0);
      drive(4, 1, 0);
      drive(3, 1, 0);
      check_eq("dn_lock", locked_dn, 1);
      drive(6, 1, 0);
      check_eq("dn_mismatch_err", err_dn, 1);
      check_eq("dn_mismatch_unlock", locked_dn, 0);
      drive(4, 1, 0);
      drive(3, 1, 0);
      check_eq("dn_hunt_relock", locked_dn, 1);

      // Randomized traffic biased toward the expected sequences.
      for (int i = 0; i < 2000; i++) begin
         int  v;
         int  pick;
         bit  q;
         bit  c;
         pick = int'($urandom_range(0, 99));
         if (pick < 55 && m_have[1])      v = exp_next(1, m_ref[1]);
         else if (pick < 75 && m_have[0]) v = exp_next(0, m_ref[0]);
         else if (pick < 90)              v = legal_q[$urandom_range(0, legal_q.size() - 1)];
         else                             v = int'($urandom_range(0, 7));
         q = ($urandom_range(0, 4) != 0);
         c = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 299) == 0) async_reset_pulse();
         drive(v, q, c);
      end

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
